// File: rtl/cam_stream_timing.sv
// Camera byte-bus capture, pixel packing and timing regeneration.
// Optional statistics (line_len/frame_lines) built when CAM_TIMING_STATS_EN is defined.
module cam_stream_timing #(
  parameter int DIN_W         = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int HSYNC_LEN     = 1,
  parameter int COL_W         = 11,
  parameter int ROW_W         = 10
) (
  input  logic                           pclk,
  input  logic                           reset,
  input  logic [DIN_W-1:0]               din,
  input  logic                           href,
  input  logic                           vsync,
  input  logic                           swap,
  output logic [DIN_W*BYTES_PER_PIX-1:0] pixel,
  output logic                           pixel_valid,
  output logic                           active_video,
  output logic                           hblank,
  output logic                           hsync,
  output logic                           vblank,
  output logic                           vsync_out,
  output logic [COL_W-1:0]               col,
  output logic [ROW_W-1:0]               row,
  output logic                           frag_err,
  output logic                           locked,
  output logic [COL_W-1:0]               line_len,
  output logic [ROW_W-1:0]               frame_lines
);

  localparam int PIX_W = DIN_W * BYTES_PER_PIX;
  localparam int CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_PIX - 1);
  localparam logic [3:0] HS_LOAD = 4'(HSYNC_LEN);

  typedef enum logic [2:0] {
    S_UNLOCKED,
    S_LINE_WAIT,
    S_ACTIVE,
    S_HGAP,
    S_VBLANK
  } state_e;

  state_e state_q, state_d;

  logic [DIN_W-1:0] din_q, din_d;
  logic             href_q, href_d;
  logic             vsync_q, vsync_d;
  logic             vs_prev_q, vs_prev_d;

  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             swap_q, swap_d;
  logic [PIX_W-1:0] acc_q, acc_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             pv_q, pv_d;
  logic             av_q, av_d;
  logic             hb_q, hb_d;
  logic             vb_q, vb_d;
  logic             vso_q, vso_d;
  logic [3:0]       hs_cnt_q, hs_cnt_d;
  logic             hs_q, hs_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             frag_q, frag_d;
  logic             locked_q, locked_d;

  logic vs_rise, vs_fall;
  logic cap, line_end, line_start, frame_start, hs_start, lk;
  logic sw;
  int   lane;

  assign vs_rise = vsync_q & ~vs_prev_q;
  assign vs_fall = ~vsync_q & vs_prev_q;

  // Frame/line state tracking on stage-1 samples.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_UNLOCKED: if (vs_fall) state_d = S_LINE_WAIT;
      S_LINE_WAIT, S_HGAP: begin
        if (vs_rise)     state_d = S_VBLANK;
        else if (href_q) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (vs_rise)      state_d = S_VBLANK;
        else if (!href_q) state_d = S_HGAP;
      end
      S_VBLANK: if (vs_fall) state_d = S_LINE_WAIT;
      default: state_d = S_UNLOCKED;
    endcase
  end

  assign cap         = (state_d == S_ACTIVE);
  assign line_start  = cap && (state_q != S_ACTIVE);
  assign line_end    = (state_q == S_ACTIVE) && (state_d != S_ACTIVE);
  assign hs_start    = (state_q == S_ACTIVE) && (state_d == S_HGAP);
  assign frame_start = (state_d == S_LINE_WAIT) &&
                       (state_q == S_UNLOCKED || state_q == S_VBLANK);
  assign lk          = (state_d != S_UNLOCKED);

  // Byte packing, counters and aligned timing outputs.
  always_comb begin
    din_d      = din;
    href_d     = href;
    vsync_d    = vsync;
    vs_prev_d  = vsync_q;
    byte_cnt_d = byte_cnt_q;
    swap_d     = swap_q;
    acc_d      = acc_q;
    pixel_d    = pixel_q;
    pv_d       = 1'b0;
    frag_d     = 1'b0;
    col_d      = col_q;
    row_d      = row_q;
    hs_cnt_d   = hs_cnt_q;
    sw         = swap_q;
    lane       = 0;

    if (cap) begin
      if (byte_cnt_q == '0) begin
        sw     = swap;
        swap_d = swap;
      end
      lane = sw ? int'(byte_cnt_q)
                : BYTES_PER_PIX - 1 - int'(byte_cnt_q);
      for (int i = 0; i < BYTES_PER_PIX; i++) begin
        if (i == lane) acc_d[i*DIN_W +: DIN_W] = din_q;
      end
      if (byte_cnt_q == LAST) begin
        pixel_d    = acc_d;
        pv_d       = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (line_end) begin
      frag_d     = (byte_cnt_q != '0);
      byte_cnt_d = '0;
    end

    if (line_start)
      col_d = '0;
    else if (pv_q && col_q != {COL_W{1'b1}})
      col_d = col_q + 1'b1;

    if (frame_start)
      row_d = '0;
    else if (line_end && row_q != {ROW_W{1'b1}})
      row_d = row_q + 1'b1;

    if (hs_start)
      hs_cnt_d = HS_LOAD;
    else if (hs_cnt_q != '0)
      hs_cnt_d = hs_cnt_q - 1'b1;
    hs_d = (hs_cnt_q != '0);

    av_d     = cap;
    hb_d     = lk && !vsync_q && !cap;
    vb_d     = lk && vsync_q;
    vso_d    = lk && vsync_q;
    locked_d = locked_q | lk;
  end

  // State and pipeline registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= S_UNLOCKED;
      din_q      <= '0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      vs_prev_q  <= 1'b0;
      byte_cnt_q <= '0;
      swap_q     <= 1'b0;
      acc_q      <= '0;
      pixel_q    <= '0;
      pv_q       <= 1'b0;
      av_q       <= 1'b0;
      hb_q       <= 1'b0;
      vb_q       <= 1'b0;
      vso_q      <= 1'b0;
      hs_cnt_q   <= '0;
      hs_q       <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      frag_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      vs_prev_q  <= vs_prev_d;
      byte_cnt_q <= byte_cnt_d;
      swap_q     <= swap_d;
      acc_q      <= acc_d;
      pixel_q    <= pixel_d;
      pv_q       <= pv_d;
      av_q       <= av_d;
      hb_q       <= hb_d;
      vb_q       <= vb_d;
      vso_q      <= vso_d;
      hs_cnt_q   <= hs_cnt_d;
      hs_q       <= hs_d;
      col_q      <= col_d;
      row_q      <= row_d;
      frag_q     <= frag_d;
      locked_q   <= locked_d;
    end
  end

  assign pixel        = pixel_q;
  assign pixel_valid  = pv_q;
  assign active_video = av_q;
  assign hblank       = hb_q;
  assign hsync        = hs_q;
  assign vblank       = vb_q;
  assign vsync_out    = vso_q;
  assign col          = col_q;
  assign row          = row_q;
  assign frag_err     = frag_q;
  assign locked       = locked_q;

`ifdef CAM_TIMING_STATS_EN
  logic [COL_W-1:0] line_len_q, line_len_d;
  logic [ROW_W-1:0] frame_lines_q, frame_lines_d;
  logic             frame_end;

  assign frame_end = (state_d == S_VBLANK) && (state_q != S_VBLANK);

  // Latch pixel count per line and line count per frame.
  always_comb begin
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (line_end)  line_len_d    = col_d;
    if (frame_end) frame_lines_d = row_d;
  end

  // Statistics registers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
`else
  assign line_len    = '0;
  assign frame_lines = '0;
`endif

endmodule

// File: tb/tb_cam_stream_timing.sv
// Bench for cam_stream_timing: line table, scoreboard of pixels,
// hand sequences for hsync, vsync-in-line, stats and mid-line reset.
module tb_cam_stream_timing;

  logic        pclk = 1'b0;
  logic        reset, href, vsync, swap;
  logic [7:0]  din;
  logic [15:0] pixel;
  logic        pixel_valid, active_video, hblank, hsync;
  logic        vblank, vsync_out, frag_err, locked;
  logic [10:0] col, line_len;
  logic [9:0]  row, frame_lines;

  cam_stream_timing #(
    .DIN_W(8), .BYTES_PER_PIX(2), .HSYNC_LEN(4),
    .COL_W(11), .ROW_W(10)
  ) dut (
    .pclk(pclk), .reset(reset), .din(din), .href(href),
    .vsync(vsync), .swap(swap), .pixel(pixel),
    .pixel_valid(pixel_valid), .active_video(active_video),
    .hblank(hblank), .hsync(hsync), .vblank(vblank),
    .vsync_out(vsync_out), .col(col), .row(row),
    .frag_err(frag_err), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] pix;
    int          c;
    int          r;
  } exp_t;

  typedef struct {
    int         nbytes;
    logic       sw;
    logic [7:0] first;
    int         frag;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;
  int   frag_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard consumer: every pixel_valid must match the oldest entry.
  always @(negedge pclk) begin
    exp_t e;
    if (frag_err) frag_cnt++;
    if (pixel_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0h expected none", pixel);
      end else begin
        e = sb_q.pop_front();
        chk("pixel", 32'(pixel), 32'(e.pix));
        chk("col", 32'(col), 32'(e.c));
        chk("row", 32'(row), 32'(e.r));
        chk("av_align", 32'(active_video), 32'd1);
      end
    end
  end

  task automatic drive_line(input int n, input logic [7:0] first,
                            input logic sw, input int r, input bit exp);
    logic [7:0] b0;
    b0 = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      href = 1'b1;
      din  = first + 8'(i);
      swap = sw;
      if (i % 2 == 0) b0 = din;
      else if (exp)
        sb_q.push_back('{pix: (sw ? {din, b0} : {b0, din}),
                         c: i / 2, r: r});
    end
    @(negedge pclk);
    href = 1'b0;
  endtask

  initial begin
    int f0;
    int hs_hi;
    bit hs_exp[7];
    hs_exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    vecs[0] = '{nbytes: 8, sw: 1'b0, first: 8'h01, frag: 0};
    vecs[1] = '{nbytes: 8, sw: 1'b0, first: 8'h01, frag: 0};
    vecs[2] = '{nbytes: 8, sw: 1'b1, first: 8'h01, frag: 0};
    vecs[3] = '{nbytes: 7, sw: 1'b0, first: 8'h11, frag: 1};
    vecs[4] = '{nbytes: 6, sw: 1'b1, first: 8'hA0, frag: 0};

    reset = 1'b1; din = '0; href = 1'b0; vsync = 1'b0; swap = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_pv", 32'(pixel_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_hblank", 32'(hblank), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    chk("rst_frame_lines", 32'(frame_lines), 32'd0);
    reset = 1'b0;

    // activity before lock is ignored
    drive_line(8, 8'h01, 1'b0, 0, 1'b0);
    repeat (4) @(negedge pclk);
    chk("prelock_locked", 32'(locked), 32'd0);
    chk("prelock_av", 32'(active_video), 32'd0);
    vsync = 1'b1;
    repeat (10) @(negedge pclk);
    chk("prelock_vsync_out", 32'(vsync_out), 32'd0);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_hblank", 32'(hblank), 32'd1);
    chk("lock_row", 32'(row), 32'd0);

    for (int i = 0; i < 5; i++) begin
      f0 = frag_cnt;
      drive_line(vecs[i].nbytes, vecs[i].first, vecs[i].sw, i, 1'b1);
      repeat (6) @(negedge pclk);
      chk("tbl_frag", 32'(frag_cnt - f0), 32'(vecs[i].frag));
      chk("tbl_row", 32'(row), 32'(i + 1));
      chk("tbl_col_end", 32'(col), 32'(vecs[i].nbytes / 2));
      chk("tbl_hblank", 32'(hblank), 32'd1);
      chk("tbl_sb_drain", 32'(sb_q.size()), 32'd0);
    end

    // hsync pulse shape after href fall
    drive_line(4, 8'h40, 1'b0, 5, 1'b1);
    for (int k = 0; k < 7; k++) begin
      @(negedge pclk);
      chk($sformatf("hsync_t%0d", k), 32'(hsync), 32'(hs_exp[k]));
    end
    repeat (3) @(negedge pclk);
    chk("hsync_row", 32'(row), 32'd6);

    // vsync rises mid-line on a partial pixel
    f0 = frag_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      href = 1'b1;
      din  = 8'h30 + 8'(i);
      swap = 1'b0;
    end
    sb_q.push_back('{pix: 16'h3031, c: 0, r: 6});
    @(negedge pclk);
    vsync = 1'b1;
    din   = 8'h33;
    hs_hi = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      href = 1'b0;
      if (hsync) hs_hi++;
    end
    chk("vsmid_hsync_cycles", 32'(hs_hi), 32'd0);
    chk("vsmid_frag", 32'(frag_cnt - f0), 32'd1);
    chk("vsmid_vblank", 32'(vblank), 32'd1);
    chk("vsmid_vsync_out", 32'(vsync_out), 32'd1);
    chk("vsmid_hblank", 32'(hblank), 32'd0);
    chk("vsmid_row", 32'(row), 32'd7);
`ifdef CAM_TIMING_STATS_EN
    chk("vsmid_line_len", 32'(line_len), 32'd1);
    chk("vsmid_frame_lines", 32'(frame_lines), 32'd7);
`else
    chk("vsmid_line_len", 32'(line_len), 32'd0);
    chk("vsmid_frame_lines", 32'(frame_lines), 32'd0);
`endif

    // statistics frame: 3 lines x 640 pixels
    repeat (5) @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    chk("stats_row_clear", 32'(row), 32'd0);
    for (int l = 0; l < 3; l++) begin
      drive_line(1280, 8'h00, 1'b0, l, 1'b1);
      repeat (6) @(negedge pclk);
    end
    chk("stats_col_end", 32'(col), 32'd640);
    vsync = 1'b1;
    repeat (4) @(negedge pclk);
    chk("stats_vblank", 32'(vblank), 32'd1);
`ifdef CAM_TIMING_STATS_EN
    chk("stats_line_len", 32'(line_len), 32'd640);
    chk("stats_frame_lines", 32'(frame_lines), 32'd3);
`else
    chk("stats_line_len", 32'(line_len), 32'd0);
    chk("stats_frame_lines", 32'(frame_lines), 32'd0);
`endif

    // reset in the middle of a line drops the partial pixel silently
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
    f0 = frag_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      href = 1'b1;
      din  = 8'h50 + 8'(i);
      swap = 1'b0;
    end
    sb_q.push_back('{pix: 16'h5051, c: 0, r: 0});
    @(negedge pclk);
    reset = 1'b1;
    href  = 1'b0;
    repeat (3) @(negedge pclk);
    chk("mrst_frag", 32'(frag_cnt - f0), 32'd0);
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_row", 32'(row), 32'd0);
    chk("mrst_col", 32'(col), 32'd0);
    chk("mrst_pixel", 32'(pixel), 32'd0);
    chk("mrst_line_len", 32'(line_len), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge pclk);
    chk("final_sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_stream_timing.md
# cam_stream_timing

Parametrised camera front-end for the video-input path: samples the raw OV7670-style byte bus (din/href/vsync) on pclk, assembles multi-byte pixels with selectable byte order, and regenerates a complete, data-aligned timing set (active_video, hblank, hsync pulse, vblank, vsync) for the video-in-to-stream bridge. It combines the capture, byte-packing and hsync edge-detect functions into one block and adds frame-lock, fragment detection and column/row counters.

## Interface
- DIN_W, 8: camera data bus width.
- BYTES_PER_PIX, 2: bytes per pixel (1–4); pixel width = DIN_W*BYTES_PER_PIX.
- HSYNC_LEN, 1: hsync pulse length in pclk cycles (1–15).
- COL_W, 11: column counter width.
- ROW_W, 10: row counter width.
- pclk  in  1  camera pixel clock; sole clock.
- reset  in  1  reset is synchronous and active-high.
- din  in  DIN_W  camera byte.
- href  in  1  line-valid from camera.
- vsync  in  1  frame sync from camera, high during vertical blanking.
- swap  in  1  0: first byte is MS byte; 1: first byte is LS byte.
- pixel  out  DIN_W*BYTES_PER_PIX  assembled pixel.
- pixel_valid  out  1  one-cycle strobe per complete pixel.
- active_video  out  1  high while a line is being delivered.
- hblank  out  1  ~active_video while locked and vsync low.
- hsync  out  1  HSYNC_LEN-cycle pulse after each line end.
- vblank, vsync_out  out  1  registered, aligned copies of vsync.
- col  out  COL_W  index of current pixel within line.
- row  out  ROW_W  index of current line within frame.
- frag_err  out  1  one-cycle pulse: line ended on partial pixel.
- locked  out  1  high once a frame boundary has been seen.
- line_len, frame_lines  out  COL_W / ROW_W  statistics (see Configuration).

## Operation
- Stage 1 registers din/href/vsync every pclk; all logic acts on stage-1 values.
- States: UNLOCKED -> (vsync fall) LINE_WAIT; LINE_WAIT -> (href rise) ACTIVE; ACTIVE -> (href fall) HGAP; HGAP -> (href rise) ACTIVE; any locked state -> (vsync rise) VBLANK; VBLANK -> (vsync fall) LINE_WAIT.
- In UNLOCKED all outputs held at reset values; locked=0. locked goes 1 on first vsync fall and stays until reset.
- Byte counter 0..BYTES_PER_PIX-1 advances each href-high cycle; at last byte pixel and pixel_valid update. swap=0: byte 0 in MS lane; swap=1: byte 0 in LS lane. swap sampled at byte 0 of each pixel.
- href fall with byte counter ≠ 0: partial bytes discarded, no pixel_valid, frag_err pulse, counter cleared.
- col clears to 0 at href rise, increments after each pixel_valid, saturates at 2^COL_W-1.
- row clears on vsync fall, increments on each href fall, saturates at 2^ROW_W-1.
- hsync: starts cycle after href fall detection, lasts HSYNC_LEN cycles; a new href fall during a pulse restarts the count.
- vsync rise while href high: line terminated (same handling as href fall, including frag_err), then VBLANK; no hsync issued.
- BYTES_PER_PIX=1: every href-high byte is a pixel; frag_err never asserts.

## Timing
- Reset values: pixel=0, pixel_valid=0, active_video=0, hblank=0, hsync=0, vblank=0, vsync_out=0, col=0, row=0, frag_err=0, locked=0, line_len=0, frame_lines=0; state UNLOCKED.
- Latency: byte present at edge N -> pixel/pixel_valid high after edge N+1 (2 edges).
- active_video, hblank, vblank, vsync_out carry the same 2-edge latency so they align with pixel_valid.
- hsync rises 3 edges after the first href-low sample.
- Reset asserted mid-line: all state cleared next edge; partial pixel dropped silently (no frag_err).

## Configuration
- CAM_TIMING_STATS_EN defined: line_len latches col count (pixels) at every line end; frame_lines latches row at every vsync rise; both hold until next update.
- Undefined: line_len and frame_lines tied to 0; statistics registers not built.

## Test plan
- Reset, vsync high 10 cycles then low, 2 lines of 8 bytes, swap=0, bytes 0x01..0x08 -> 4 pixel_valid per line, pixels 0x0102,0x0304,0x0506,0x0708, col 0..3, row 0 then 1.
- Same with swap=1 -> pixels 0x0201,0x0403,0x0605,0x0807.
- Line of 7 bytes -> 3 pixels, frag_err single pulse at line end, row still increments.
- HSYNC_LEN=4, 6-cycle href gap -> hsync high exactly 4 cycles, rising 3 edges after href fall.
- href activity before first vsync fall -> no pixel_valid, locked=0; after vsync fall, locked=1 and capture starts.
- With CAM_TIMING_STATS_EN, frame of 3 lines x 640 pixels -> line_len=640, frame_lines=3 after vsync rise; without macro both read 0.
